acorn_sample_fifo: RTL and testbench

Downstream consumer of the 12-bit ACORN generator output word. It tracks the generator's 16-cycle update cadence and captures each fresh word exactly once. Captured words go into a small FIFO drained through a valid/ready port; the LA/Wishbone-side logic reads from that port. It also runs a stuck-output health check and keeps sticky overflow and health flags for firmware.

---
 rtl/acorn_pkg.sv | 16 +
 rtl/acorn_sync_fifo.sv | 63 ++++++
 rtl/acorn_sample_fifo.sv | 121 ++++++++++++
 tb/tb_acorn_sample_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acorn_pkg.sv
// Shared ACORN definitions: word width, fixed seeds and seed-select encodings.
package acorn_pkg;

    localparam int WORD_W = 12;

    localparam logic [WORD_W-1:0] SEED_FIXED = 12'h801;
    localparam logic [WORD_W-1:0] SEED_ONES  = 12'hFFF;

    typedef enum logic [1:0] {
        SEL_FIXED = 2'b00,
        SEL_GPIO  = 2'b01,
        SEL_LA    = 2'b10,
        SEL_ONES  = 2'b11
    } seed_sel_e;

endpackage

// File: rtl/acorn_sync_fifo.sv
// Single-clock FIFO with registered storage, occupancy count and soft clear.
module acorn_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    // Clear wins over any same-cycle traffic; a push into a full FIFO needs a pop.
    assign w_pop  = i_pop && !o_empty && !i_clear;
    assign w_push = i_push && !i_clear && (!o_full || w_pop);

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage is deliberately not reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/acorn_sample_fifo.sv
// Captures each fresh ACORN word once per generator period into a FIFO,
// with sticky overflow and stuck-output health flags.
module acorn_sample_fifo
    import acorn_pkg::*;
#(
    parameter int PERIOD       = 16,
    parameter int DEPTH        = 4,
    parameter int REPEAT_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WORD_W-1:0]       prng_out,
    input  logic                    clear,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [WORD_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    sample_strobe,
    output logic                    overflow,
    output logic                    health_fail
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CW = $clog2(REPEAT_LIMIT + 1);

    logic [PW-1:0]     r_phase;
    logic              r_armed;
    logic              r_seen;
    logic [WORD_W-1:0] r_prev;
    logic [CW-1:0]     r_repeat_cnt;
    logic              r_overflow;
    logic              r_health_fail;

    logic              w_capture;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_is_repeat;
    logic [CW-1:0]     w_cnt_next;

    assign w_capture = !reset && !load && r_armed && (r_phase == '0);
    assign w_pop     = !w_empty && rd_ready && !clear;
    assign w_push    = w_capture && !clear && (!w_full || w_pop);
    assign w_drop    = w_capture && !clear && w_full && !w_pop;

    // The first capture after reset or clear only seeds r_prev.
    assign w_is_repeat = r_seen && (prng_out == r_prev);

    always_comb begin
        w_cnt_next = '0;
        if (w_is_repeat) begin
            w_cnt_next = (r_repeat_cnt == CW'(REPEAT_LIMIT)) ? r_repeat_cnt
                                                             : r_repeat_cnt + 1'b1;
        end
    end

    // Phase mirrors the generator's cadence counter, which pauses during load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_armed <= 1'b0;
        end else if (!load) begin
            r_phase <= r_phase + 1'b1;
            if (r_phase == PW'(PERIOD - 1)) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen        <= 1'b0;
            r_prev        <= '0;
            r_repeat_cnt  <= '0;
            r_overflow    <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (clear) begin
            r_seen        <= 1'b0;
            r_repeat_cnt  <= '0;
            r_overflow    <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_capture) begin
                r_seen       <= 1'b1;
                r_prev       <= prng_out;
                r_repeat_cnt <= w_cnt_next;
                if (w_cnt_next == CW'(REPEAT_LIMIT)) begin
                    r_health_fail <= 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    acorn_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (prng_out),
        .o_data  (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign rd_valid      = !w_empty;
    assign sample_strobe = w_capture;
    assign overflow      = r_overflow;
    assign health_fail   = r_health_fail;

endmodule

// File: tb/tb_acorn_sample_fifo.sv
// Directed bench for acorn_sample_fifo: stimulus queues expected words, a
// negedge monitor pops and compares every word the consumer accepts.
module tb_acorn_sample_fifo;
    import acorn_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [WORD_W-1:0] prng_out = '0;
    logic              clear = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic [2:0]        level;
    logic              sample_strobe;
    logic              overflow;
    logic              health_fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last = 0;
    logic [WORD_W-1:0] exp_q [$];

    acorn_sample_fifo #(
        .PERIOD       (16),
        .DEPTH        (4),
        .REPEAT_LIMIT (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .prng_out      (prng_out),
        .clear         (clear),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .level         (level),
        .sample_strobe (sample_strobe),
        .overflow      (overflow),
        .health_fail   (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Step until the next capture strobe (bounded) and check the gap since the last one.
    task automatic wait_strobe(input int gap, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sample_strobe && n < 64);
        check(name, cyc - last, gap);
        last = cyc;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step();
        rd_ready = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected nothing", rd_data);
            end else begin
                check("pop_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) step();
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_health", health_fail, 0);
        check("rst_strobe", sample_strobe, 0);
        reset = 1'b0;
        last = cyc;

        // Fill with distinct words, consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            prng_out = 12'(i);
            wait_strobe(16, "gap_fill");
            exp_q.push_back(12'(i));
            step();
            check("level_fill", level, i);
            if (i == 1) begin
                check("first_valid", rd_valid, 1);
                check("first_data", rd_data, 12'h001);
            end
        end

        // Fifth capture while full is dropped.
        prng_out = 12'h005;
        wait_strobe(16, "gap_drop");
        step();
        check("overflow_set", overflow, 1);
        check("level_full", level, 4);
        check("head_after_drop", rd_data, 12'h001);
        drain(4);
        check("level_drained", level, 0);
        check("valid_drained", rd_valid, 0);
        check("data_empty", rd_data, 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        check("overflow_cleared", overflow, 0);

        // Full with a pop on the capture cycle: push and pop together.
        for (int w = 6; w <= 9; w++) begin
            prng_out = 12'(w);
            wait_strobe(16, "gap_refill");
            exp_q.push_back(12'(w));
            step();
            check("level_refill", level, w - 5);
        end
        prng_out = 12'h00A;
        wait_strobe(16, "gap_pushpop");
        rd_ready = 1'b1;
        exp_q.push_back(12'h00A);
        step();
        rd_ready = 1'b0;
        #1;
        check("level_pushpop", level, 4);
        check("overflow_pushpop", overflow, 0);
        check("head_pushpop", rd_data, 12'h007);
        drain(4);
        check("level_drained2", level, 0);

        // Stuck output: fourth identical capture is the third repeat.
        prng_out = 12'hABC;
        for (int k = 1; k <= 4; k++) begin
            wait_strobe(16, "gap_health");
            exp_q.push_back(12'hABC);
            step();
            check("health_flag", health_fail, (k == 4) ? 1 : 0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        exp_q.delete();
        check("clear_health", health_fail, 0);
        check("clear_overflow", overflow, 0);
        check("clear_level", level, 0);
        check("clear_valid", rd_valid, 0);

        // Load for 5 cycles mid-period delays the next capture by 5.
        repeat (3) step();
        prng_out = 12'h123;
        load = 1'b1;
        repeat (5) step();
        load = 1'b0;
        wait_strobe(21, "gap_load_mid");
        exp_q.push_back(12'h123);

        // Load held across a phase-0 cycle: capture waits for load to drop.
        prng_out = 12'h456;
        repeat (16) step();
        load = 1'b1;
        #1;
        check("strobe_loaded", sample_strobe, 0);
        repeat (3) step();
        load = 1'b0;
        #1;
        check("strobe_unloaded", sample_strobe, 1);
        check("gap_load_phase0", cyc - last, 19);
        last = cyc;
        exp_q.push_back(12'h456);
        step();
        check("level_after_load", level, 2);

        // Reset with three entries queued.
        prng_out = 12'h789;
        wait_strobe(16, "gap_third");
        exp_q.push_back(12'h789);
        step();
        check("level_pre_reset", level, 3);
        check("health_distinct", health_fail, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        exp_q.delete();
        last = cyc;
        check("reset_level", level, 0);
        check("reset_valid", rd_valid, 0);
        prng_out = 12'h0F0;
        wait_strobe(16, "gap_after_reset");
        exp_q.push_back(12'h0F0);
        step();
        check("data_after_reset", rd_data, 12'h0F0);
        check("level_after_reset", level, 1);
        drain(1);
        check("level_final", level, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
